// File: rtl/cplx_mac_acc_pkg.sv
// Shared MIMO detector datapath widths and the round/saturate helper.
// Latency: none, constants and a pure combinational function.
// Backpressure: not applicable.
package mimo_pkg;

   localparam int DATA_W   = 28;
   localparam int PROD_W   = 56;
   localparam int ACC_W    = 58;
   localparam int FRAC_DEF = 14;

   // Rounded/clamped component together with its saturation indication.
   typedef struct packed {
      logic                     sat;
      logic signed [DATA_W-1:0] val;
   } rs_t;

   // Accumulation phase: first term of an inner product, or a later one.
   typedef enum logic {
      ST_ACC0 = 1'b0,
      ST_ACCK = 1'b1
   } acc_state_t;

   // Round half toward +inf, arithmetic shift by frac, clamp to DATA_W signed.
   // One guard bit is added because a near-full-scale sum plus the rounding
   // half can exceed the ACC_W signed range.
   function automatic rs_t sat_round(input logic signed [ACC_W-1:0] x,
                                     input int                      frac);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] half;
      logic signed [ACC_W:0] sh;
      logic                  ovf;
      rs_t                   r;
      ext  = {x[ACC_W-1], x};
      half = {{ACC_W{1'b0}}, 1'b1} << (frac - 1);
      sh   = (ext + half) >>> frac;
      // In range only if every bit above the result sign copies the sign.
      ovf  = (sh[ACC_W:DATA_W-1] != {(ACC_W-DATA_W+2){sh[ACC_W]}});
      r.sat = ovf;
      if (!ovf) begin
         r.val = sh[DATA_W-1:0];
      end else if (sh[ACC_W]) begin
         r.val = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         r.val = {1'b0, {(DATA_W-1){1'b1}}};
      end
      return r;
   endfunction

endpackage

// File: rtl/cplx_mac_acc_if.sv
// Product-in / result-out handshake bundle of the complex MAC back end.
// Latency: wires only.
// Backpressure: valid/ready on both the product and the result side.
interface cplx_mac_acc_if;
   import mimo_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic signed [PROD_W-1:0] real_prod;
   logic signed [PROD_W-1:0] imag_prod;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] real_out;
   logic signed [DATA_W-1:0] imag_out;
   logic                     sat_flag;

   // Accumulator side.
   modport slave (
      input  in_valid, real_prod, imag_prod, out_ready,
      output in_ready, out_valid, real_out, imag_out, sat_flag
   );

   // Product source / result sink side.
   modport master (
      output in_valid, real_prod, imag_prod, out_ready,
      input  in_ready, out_valid, real_out, imag_out, sat_flag
   );

endinterface

// File: rtl/cplx_mac_acc_round_sat.sv
// Rounds an accumulated sum to DATA_W Q.14 with saturation.
// Latency: combinational.
// Backpressure: none, pure datapath.
module round_sat
   import mimo_pkg::*;
#(
   parameter int FRAC = FRAC_DEF
) (
   input  logic signed [ACC_W-1:0]  sum_i,
   output logic signed [DATA_W-1:0] res_o,
   output logic                     sat_o
);

   rs_t rs;

   // Single shared implementation of round-half-up, shift and clamp.
   always_comb begin
      rs = sat_round(sum_i, FRAC);
   end

   assign res_o = rs.val;
   assign sat_o = rs.sat;

endmodule

// File: rtl/cplx_mac_acc.sv
// Sums N_TERMS complex products, rounds/saturates to Q.14, registers result.
// Latency: result valid 1 cycle after the last term is accepted.
// Backpressure: in_ready = !out_valid || out_ready; full result stalls input.
module cplx_mac_acc
   import mimo_pkg::*;
#(
   parameter int N_TERMS = 2,
   parameter int FRAC    = FRAC_DEF
) (
   input logic           clk,
   input logic           rst,
   cplx_mac_acc_if.slave bus
);

   localparam logic [1:0] LAST_CNT = 2'(N_TERMS - 1);

   acc_state_t               st_q, st_d;
   logic [1:0]               cnt_q, cnt_d;
   logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
   logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] real_q, real_d;
   logic signed [DATA_W-1:0] imag_q, imag_d;
   logic                     sat_q, sat_d;

   logic                     in_ready;
   logic                     accept;
   logic                     last;
   logic signed [ACC_W-1:0]  base_re, base_im;
   logic signed [ACC_W-1:0]  sum_re, sum_im;
   logic signed [DATA_W-1:0] rnd_re, rnd_im;
   logic                     sat_re, sat_im;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign last     = (cnt_q == LAST_CNT);

   // Running sum including the incoming product; first term starts from zero.
   always_comb begin
      base_re = acc_re_q;
      base_im = acc_im_q;
      if (st_q == ST_ACC0) begin
         base_re = '0;
         base_im = '0;
      end
      sum_re = base_re + ACC_W'(bus.real_prod);
      sum_im = base_im + ACC_W'(bus.imag_prod);
   end

   round_sat #(.FRAC(FRAC)) u_rs_re (
      .sum_i (sum_re),
      .res_o (rnd_re),
      .sat_o (sat_re)
   );

   round_sat #(.FRAC(FRAC)) u_rs_im (
      .sum_i (sum_im),
      .res_o (rnd_im),
      .sat_o (sat_im)
   );

   // Next state: term counter/phase, accumulators and output register.
   always_comb begin
      st_d        = st_q;
      cnt_d       = cnt_q;
      acc_re_d    = acc_re_q;
      acc_im_d    = acc_im_q;
      out_valid_d = out_valid_q;
      real_d      = real_q;
      imag_d      = imag_q;
      sat_d       = sat_q;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         acc_re_d = sum_re;
         acc_im_d = sum_im;
         if (last) begin
            st_d        = ST_ACC0;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            real_d      = rnd_re;
            imag_d      = rnd_im;
            sat_d       = sat_re | sat_im;
         end else begin
            st_d  = ST_ACCK;
            cnt_d = cnt_q + 2'd1;
         end
      end
   end

   // State register with synchronous reset; a partial sum is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= ST_ACC0;
         cnt_q       <= '0;
         acc_re_q    <= '0;
         acc_im_q    <= '0;
         out_valid_q <= 1'b0;
         real_q      <= '0;
         imag_q      <= '0;
         sat_q       <= 1'b0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         acc_re_q    <= acc_re_d;
         acc_im_q    <= acc_im_d;
         out_valid_q <= out_valid_d;
         real_q      <= real_d;
         imag_q      <= imag_d;
         sat_q       <= sat_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.real_out  = real_q;
   assign bus.imag_out  = imag_q;
   assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_cplx_mac_acc.sv
// Directed bench for cplx_mac_acc: vector table plus multi-cycle sequences.
// Latency: checks results 1 cycle after the last term.
// Backpressure: exercises stalled output and in_ready drop.
module tb_cplx_mac_acc;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   cplx_mac_acc_if if2 ();
   cplx_mac_acc_if if1 ();

   cplx_mac_acc #(.N_TERMS(2), .FRAC(14)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   cplx_mac_acc #(.N_TERMS(1), .FRAC(14)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Result collectors: record each handshaken result and the cycle it left.
   logic mon_en = 1'b0;
   int   q2_val[$];
   int   q2_cyc[$];
   int   q1_val[$];
   int   q1_cyc[$];

   always @(negedge clk) begin
      if (mon_en && if2.out_valid && if2.out_ready) begin
         q2_val.push_back(int'(if2.real_out));
         q2_cyc.push_back(cyc);
      end
      if (mon_en && if1.out_valid && if1.out_ready) begin
         q1_val.push_back(int'(if1.real_out));
         q1_cyc.push_back(cyc);
      end
   end

   typedef struct {
      logic signed [55:0] re0;
      logic signed [55:0] im0;
      logic signed [55:0] re1;
      logic signed [55:0] im1;
      int                 exp_re;
      int                 exp_im;
      logic               exp_sat;
   } vec_t;

   vec_t vecs[9];

   function automatic logic signed [55:0] p2(input int e);
      logic signed [55:0] one;
      one = 56'sd1;
      return one <<< e;
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Offer one product to the N_TERMS=2 instance and hold it until accepted.
   task automatic send2(input logic signed [55:0] re, input logic signed [55:0] im);
      int t;
      t = 0;
      if2.real_prod = re;
      if2.imag_prod = im;
      if2.in_valid  = 1'b1;
      @(negedge clk);
      while (!if2.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("send2_timeout", 1, 0);
      @(posedge clk);
      #1;
      if2.in_valid = 1'b0;
   endtask

   initial begin
      if2.in_valid  = 1'b0;
      if2.real_prod = '0;
      if2.imag_prod = '0;
      if2.out_ready = 1'b1;
      if1.in_valid  = 1'b0;
      if1.real_prod = '0;
      if1.imag_prod = '0;
      if1.out_ready = 1'b1;

      vecs[0] = '{p2(28), 56'sd0, p2(28), -p2(28), 32768, -16384, 1'b0};
      vecs[1] = '{p2(13), -p2(13), p2(13), 56'sd0, 1, 0, 1'b0};
      vecs[2] = '{p2(41), -p2(41), p2(41), -p2(41), 134217727, -134217728, 1'b1};
      vecs[3] = '{-p2(28), 3 * p2(14), 56'sd0, p2(13), -16384, 4, 1'b0};
      vecs[4] = '{-3 * p2(13), 56'sd0, 56'sd0, 56'sd0, -1, 0, 1'b0};
      vecs[5] = '{p2(41) - p2(14), -p2(41), 56'sd0, 56'sd0, 134217727, -134217728, 1'b0};
      vecs[6] = '{p2(41) - p2(14) + p2(13), 56'sd0, 56'sd0, 56'sd0, 134217727, 0, 1'b1};
      vecs[7] = '{-p2(13), 56'sd0, 56'sd0, 56'sd0, 0, 0, 1'b0};
      vecs[8] = '{-p2(41) - p2(13), -p2(41) - p2(13) - 56'sd1, 56'sd0, 56'sd0,
                  -134217728, -134217728, 1'b1};

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", if2.in_ready, 1);
      check("rst_out_valid", if2.out_valid, 0);
      check("rst_real_out", if2.real_out, 0);
      check("rst_imag_out", if2.imag_out, 0);
      check("rst_sat_flag", if2.sat_flag, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table of two-term inner products with out_ready held high.
      for (int i = 0; i < 9; i++) begin
         send2(vecs[i].re0, vecs[i].im0);
         send2(vecs[i].re1, vecs[i].im1);
         check($sformatf("vec%0d_out_valid", i), if2.out_valid, 1);
         check($sformatf("vec%0d_real_out", i), if2.real_out, vecs[i].exp_re);
         check($sformatf("vec%0d_imag_out", i), if2.imag_out, vecs[i].exp_im);
         check($sformatf("vec%0d_sat_flag", i), if2.sat_flag, vecs[i].exp_sat);
      end
      @(posedge clk);
      #1;

      // Sustained throughput: back-to-back inner products every 2 cycles.
      q2_val.delete();
      q2_cyc.delete();
      mon_en = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         send2(56'(k) * p2(28), 56'sd0);
         send2(56'(k) * p2(28), 56'sd0);
      end
      repeat (3) @(posedge clk);
      #1;
      check("tput_count", q2_val.size(), 3);
      if (q2_val.size() == 3) begin
         for (int k = 0; k < 3; k++) check($sformatf("tput_val%0d", k), q2_val[k], (k + 1) * 32768);
         check("tput_gap01", q2_cyc[1] - q2_cyc[0], 2);
         check("tput_gap12", q2_cyc[2] - q2_cyc[1], 2);
      end

      // Backpressure: first result held for 5 cycles, then drained in order.
      q2_val.delete();
      q2_cyc.delete();
      if2.out_ready = 1'b0;
      fork
         begin
            for (int k = 1; k <= 3; k++) begin
               send2(56'(k) * p2(28), 56'sd0);
               send2(56'(k) * p2(28), 56'sd0);
            end
         end
         begin
            int t;
            t = 0;
            @(negedge clk);
            while (!if2.out_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            if (t >= 50) check("bp_first_timeout", 1, 0);
            for (int c = 0; c < 5; c++) begin
               check($sformatf("bp_in_ready_c%0d", c), if2.in_ready, 0);
               check($sformatf("bp_hold_valid_c%0d", c), if2.out_valid, 1);
               check($sformatf("bp_hold_real_c%0d", c), if2.real_out, 32768);
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            if2.out_ready = 1'b1;
         end
      join
      begin
         int t;
         t = 0;
         while (q2_val.size() < 3 && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (t >= 100) check("bp_drain_timeout", 1, 0);
      end
      check("bp_count", q2_val.size(), 3);
      if (q2_val.size() == 3) begin
         for (int k = 0; k < 3; k++) check($sformatf("bp_val%0d", k), q2_val[k], (k + 1) * 32768);
      end
      mon_en = 1'b0;
      @(posedge clk);
      #1;

      // Reset mid-accumulation discards the partial sum.
      send2(56'sd5 * p2(28), 56'sd7 * p2(28));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_in_ready", if2.in_ready, 1);
      check("mid_rst_out_valid", if2.out_valid, 0);
      check("mid_rst_real_out", if2.real_out, 0);
      check("mid_rst_imag_out", if2.imag_out, 0);
      check("mid_rst_sat_flag", if2.sat_flag, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send2(p2(28), 56'sd0);
      check("post_rst_no_early_valid", if2.out_valid, 0);
      send2(p2(28), 56'sd0);
      check("post_rst_valid", if2.out_valid, 1);
      check("post_rst_real", if2.real_out, 32768);
      check("post_rst_imag", if2.imag_out, 0);
      @(posedge clk);
      #1;

      // Single-term inner products on the N_TERMS=1 instance.
      q1_val.delete();
      q1_cyc.delete();
      mon_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         if1.real_prod = 56'(k) * p2(28);
         if1.imag_prod = 56'sd0;
         if1.in_valid  = 1'b1;
         @(posedge clk);
         #1;
      end
      if1.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("n1_count", q1_val.size(), 4);
      if (q1_val.size() == 4) begin
         for (int k = 0; k < 4; k++) check($sformatf("n1_val%0d", k), q1_val[k], (k + 1) * 16384);
         for (int k = 1; k < 4; k++) check($sformatf("n1_gap%0d", k), q1_cyc[k] - q1_cyc[k-1], 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cplx_mac_acc.md
# cplx_mac_acc

Complex multiply-accumulate back end for the QR-based MIMO detector. Consumes the stream of 56-bit full-precision complex products from the complex multiplier and sums `N_TERMS` consecutive products into one inner product, for example one row of Q^H·y or one R·x term. Rounds the sum back to the 28-bit Q.14 datapath format with saturation. Presents the result on a valid/ready output register to the next detector stage.

## Interface
- `N_TERMS`, 2: products per inner product; legal range 1..4.
- `FRAC`, 14: right-shift applied to the accumulated sum, with rounding; legal range 1..27.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  a product is present on `real_prod`/`imag_prod`.
- `in_ready`  out  1  block accepts the product this cycle.
- `real_prod`  in  56 signed  real part of the product (Q.28).
- `imag_prod`  in  56 signed  imaginary part of the product (Q.28).
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  downstream takes the result this cycle.
- `real_out`  out  28 signed  rounded and saturated real sum (Q.14).
- `imag_out`  out  28 signed  rounded and saturated imaginary sum (Q.14).
- `sat_flag`  out  1  set if either output component saturated in the current result.

## Operation
- Accept rule: a product is accepted when `in_valid && in_ready`.
- Ready rule: `in_ready = !out_valid || out_ready`, evaluated combinationally. There is no other stall source.
- Term counter `cnt` runs 0..N_TERMS-1:
  - An accept with `cnt==0` loads `acc` with the product.
  - Any other accept adds the product to `acc`.
  - `cnt` increments on each accept and wraps to 0 after the term where `cnt==N_TERMS-1`.
- Accumulators: `acc_re` and `acc_im` are 58-bit signed. Inputs are sign-extended to 58 bits, so at most 4 terms cannot overflow.
- Finish on the last term (accept with `cnt==N_TERMS-1`):
  - `sum = acc + prod`, with `acc` read as 0 when `N_TERMS==1`.
  - `r = (sum + 2^(FRAC-1)) >>> FRAC`: arithmetic shift, round half toward +infinity.
  - Each component is clamped to [-2^27, 2^27-1].
  - `real_out`, `imag_out` and `sat_flag` are loaded into the output register, and `out_valid` is set.
- `out_valid` clears on `out_valid && out_ready` unless a finish happens in the same cycle. In that case the register reloads and `out_valid` stays 1.
- The output register holds its value while `out_valid && !out_ready`. Since `in_ready` is 0 then, `acc` and `cnt` also hold.
- FSM view, with `cnt` as state:
  - ACC0: `cnt==0`, moves to ACCk on accept.
  - ACCk: moves to ACC0 when the last term is accepted.
  - The output register is an independent full/empty flag.
- Reset clears `cnt`, `acc_re`, `acc_im`, `out_valid`, `real_out`, `imag_out` and `sat_flag` to 0, including reset in the middle of an accumulation. A partial sum is discarded.

## Timing
- Latency: the result is valid 1 cycle after the last term is accepted. Nothing is combinational from `*_prod` to `*_out`.
- Throughput: one product per cycle sustained while `out_ready` is held high. Consecutive inner products follow with no bubble.
- Reset values (all outputs): `in_ready=1`, `out_valid=0`, `real_out=0`, `imag_out=0`, `sat_flag=0`.
- Output stability: `real_out`, `imag_out` and `sat_flag` only change when the register loads. They are stable throughout `out_valid && !out_ready`.
- Inputs while `in_ready==0` are ignored. Upstream must hold its product until accepted.

## Structure
- Shared package `mimo_pkg` holds:
  - `DATA_W=28`, `PROD_W=56`, `ACC_W=58`, `FRAC_DEF=14`;
  - a `sat_round` function signature: 58-bit in, 28-bit out, plus a saturation bit.
- One sub-module, `round_sat` (combinational), is instantiated twice, once for real and once for imaginary. It implements round-half-up, the shift by `FRAC`, and the clamp, and outputs its own saturation bit.
- The top level contains the counter, the accumulators, the output register and the handshake logic.

## Test plan
All scenarios use `N_TERMS=2` and `FRAC=14` unless stated.
- Basic sum: products (2^28, 0) and (2^28, -2^28) on consecutive cycles with `out_ready=1` -> one cycle after the second accept, `real_out=32768`, `imag_out=-16384`, `sat_flag=0`.
- Rounding: products (2^13, -2^13) and (2^13, 0) -> `real_out=1`, `imag_out=0`. A sum of -2^13 rounds to 0.
- Saturation: products (2^41, -2^41) twice -> `real_out=134217727`, `imag_out=-134217728`, `sat_flag=1`.
- Backpressure: 3 back-to-back inner products, `out_ready=0` for 5 cycles after the first result -> `in_ready` is 0 while blocked, the first result holds unchanged, and all 3 results arrive in order with none lost. With `out_ready=1` throughout, results appear every 2 cycles.
- Reset mid-operation: assert `rst` after 1 of 2 terms is accepted, then feed 2 new terms (2^28, 0) twice -> the result is exactly 32768, with no residue from the discarded term. All outputs are 0 during reset.
- `N_TERMS=1`: a stream of (2^28·k, 0) for k=1..4 with `out_ready=1` -> `real_out` is 16384·k on consecutive cycles.
